// File: rtl/gnr_pkg.sv
// Shared types, sizing helpers and truth-table constants for the GRN node array.
package gnr_pkg;

  // 2**n entries in an n-input truth table
  function automatic int unsigned lut_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Low bit of element idx in a packed bus of w-bit elements
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

  localparam logic [7:0] TT_AND = 8'h80;
  localparam logic [7:0] TT_OR  = 8'hFE;

endpackage

// File: rtl/gnr_lut_stream.sv
// One state copy of a LUT node: stride phase counter, state register, update flags.
module gnr_lut_stream
  import gnr_pkg::*;
#(
  parameter int unsigned N_IN = 3,
  parameter int unsigned SW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reset_nos,
  input  logic                     init_val,
  input  logic                     start,
  input  logic [SW-1:0]            stride,
  input  logic [N_IN-1:0]          idx,
  input  logic [lut_w(N_IN)-1:0]   tt,
  output logic                     state,
  output logic                     upd_v,
  output logic                     changed
);

  logic [SW-1:0] phase;
  logic [SW-1:0] reload;
  logic          next_val;
  logic          apply;

  always_comb begin
    next_val = tt[idx];
    reload   = (stride == '0) ? '0 : stride - SW'(1);
    apply    = start && (phase == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= 1'b0;
      phase   <= '0;
      upd_v   <= 1'b0;
      changed <= 1'b0;
    end else if (reset_nos) begin
      state   <= init_val;
      phase   <= '0;
      upd_v   <= 1'b0;
      changed <= 1'b0;
    end else if (apply) begin
      state   <= next_val;
      phase   <= reload;
      upd_v   <= 1'b1;
      changed <= (next_val != state);
    end else begin
      upd_v   <= 1'b0;
      changed <= 1'b0;
      if (start) phase <= phase - SW'(1);
    end
  end

endmodule

// File: rtl/gnr_node_lut.sv
// Generalised Boolean-network node: shared runtime truth table, N_STREAMS strided state copies.
module gnr_node_lut
  import gnr_pkg::*;
#(
  parameter int unsigned        N_IN      = 3,
  parameter int unsigned        N_STREAMS = 2,
  parameter int unsigned        SW        = 4,
  parameter logic [2**N_IN-1:0] TT_RESET  = TT_AND
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [2**N_IN-1:0]          cfg_tt,
  input  logic                        reset_nos,
  input  logic [N_STREAMS-1:0]        init_state,
  input  logic [N_STREAMS-1:0]        start,
  input  logic [N_STREAMS*SW-1:0]     stride,
  input  logic [N_STREAMS*N_IN-1:0]   in_vals,
  output logic [N_STREAMS-1:0]        state,
  output logic [N_STREAMS-1:0]        upd_v,
  output logic [N_STREAMS-1:0]        changed,
  output logic                        all_eq
);

  logic [lut_w(N_IN)-1:0] tt;

  // Streams read the registered table, so a same-cycle load only affects later starts
  always_ff @(posedge clk) begin
    if (rst)         tt <= TT_RESET;
    else if (cfg_we) tt <= cfg_tt;
  end

  for (genvar i = 0; i < N_STREAMS; i++) begin : g_stream
    gnr_lut_stream #(
      .N_IN (N_IN),
      .SW   (SW)
    ) u_stream (
      .clk       (clk),
      .rst       (rst),
      .reset_nos (reset_nos),
      .init_val  (init_state[i]),
      .start     (start[i]),
      .stride    (stride[slice_lo(i, SW) +: SW]),
      .idx       (in_vals[slice_lo(i, N_IN) +: N_IN]),
      .tt        (tt),
      .state     (state[i]),
      .upd_v     (upd_v[i]),
      .changed   (changed[i])
    );
  end

  always_comb all_eq = (state == '0) || (state == '1);

endmodule

// File: tb/tb_gnr_node_lut.sv
// Scoreboard bench for gnr_node_lut: directed vectors push expected post-edge outputs, a monitor checks them.
module tb_gnr_node_lut;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_tt;
  logic       reset_nos;
  logic [1:0] init_state;
  logic [1:0] start;
  logic [7:0] stride;
  logic [5:0] in_vals;
  logic [1:0] state;
  logic [1:0] upd_v;
  logic [1:0] changed;
  logic       all_eq;

  typedef struct {
    int         vec;
    logic [1:0] st;
    logic [1:0] upd;
    logic [1:0] chg;
    logic       eq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  gnr_node_lut #(
    .N_IN      (3),
    .N_STREAMS (2),
    .SW        (4),
    .TT_RESET  (8'h80)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_tt     (cfg_tt),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start      (start),
    .stride     (stride),
    .in_vals    (in_vals),
    .state      (state),
    .upd_v      (upd_v),
    .changed    (changed),
    .all_eq     (all_eq)
  );

  task automatic chk(input string name, input int vec, input logic [1:0] act, input logic [1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %b expected %b", vec, name, act, expv);
    end
  endtask

  // Monitor: each cycle with a pending expectation is checked 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chg_check: begin
        chk("upd_v",   e.vec, upd_v,  e.upd);
        chk("state",   e.vec, state,  e.st);
        chk("all_eq",  e.vec, {1'b0, all_eq}, {1'b0, e.eq});
        for (int i = 0; i < 2; i++)
          if (upd_v[i]) chk($sformatf("changed[%0d]", i), e.vec, {1'b0, changed[i]}, {1'b0, e.chg[i]});
        if (upd_v !== e.upd) chk("changed_when_idle", e.vec, changed, e.chg);
      end
    end
  end

  int vec_no = 0;

  // Drive one cycle of stimulus and record the hand-computed outputs after the next edge
  task automatic step(input logic r, input logic rn, input logic cw, input logic [7:0] tt,
                      input logic [1:0] init, input logic [1:0] st,
                      input logic [3:0] s0, input logic [3:0] s1,
                      input logic [2:0] in0, input logic [2:0] in1,
                      input logic [1:0] es, input logic [1:0] eu, input logic [1:0] ec);
    exp_t e;
    @(negedge clk);
    rst        = r;
    reset_nos  = rn;
    cfg_we     = cw;
    cfg_tt     = tt;
    init_state = init;
    start      = st;
    stride     = {s1, s0};
    in_vals    = {in1, in0};
    vec_no++;
    e.vec = vec_no;
    e.st  = es;
    e.upd = eu;
    e.chg = ec;
    e.eq  = (es == 2'b00) || (es == 2'b11);
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; reset_nos = 1'b0; cfg_we = 1'b0; cfg_tt = '0;
    init_state = '0; start = '0; stride = '0; in_vals = '0;
    //    rst rn cw tt     init   st     s0 s1 in0 in1   state  upd    chg
    step(1, 0, 0, 8'h00, 2'b00, 2'b11, 1, 1, 7, 7, 2'b00, 2'b00, 2'b00);  // 1 reset
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 1, 1, 7, 7, 2'b11, 2'b11, 2'b11);  // 2 AND of 111
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 1, 1, 7, 7, 2'b11, 2'b11, 2'b00);  // 3 identical update
    step(0, 0, 1, 8'h01, 2'b00, 2'b11, 1, 1, 0, 0, 2'b00, 2'b11, 2'b11);  // 4 load NOR, old table used
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 1, 1, 0, 0, 2'b11, 2'b11, 2'b11);  // 5 NOR(000)=1
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 1, 1, 1, 1, 2'b00, 2'b11, 2'b11);  // 6 NOR(001)=0
    step(0, 0, 1, 8'hFE, 2'b00, 2'b00, 1, 1, 1, 1, 2'b00, 2'b00, 2'b00);  // 7 load OR
    step(0, 1, 0, 8'h00, 2'b00, 2'b00, 1, 1, 1, 1, 2'b00, 2'b00, 2'b00);  // 8 reset_nos
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 2, 1, 1, 1, 2'b11, 2'b11, 2'b11);  // 9 stride 2 / 1
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 2, 1, 1, 1, 2'b11, 2'b10, 2'b00);  // 10
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 2, 1, 1, 1, 2'b11, 2'b11, 2'b00);  // 11
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 2, 1, 1, 1, 2'b11, 2'b10, 2'b00);  // 12
    step(0, 1, 0, 8'h00, 2'b00, 2'b00, 3, 1, 0, 0, 2'b00, 2'b00, 2'b00);  // 13 reset_nos
    step(0, 0, 0, 8'h00, 2'b00, 2'b01, 3, 1, 1, 0, 2'b01, 2'b01, 2'b01);  // 14 stride 3, start 1
    step(0, 0, 0, 8'h00, 2'b00, 2'b01, 3, 1, 0, 0, 2'b01, 2'b00, 2'b00);  // 15 start 2 counts down
    step(0, 1, 0, 8'h00, 2'b10, 2'b01, 3, 1, 0, 0, 2'b10, 2'b00, 2'b00);  // 16 reset_nos beats start
    step(0, 0, 0, 8'h00, 2'b00, 2'b01, 3, 1, 1, 0, 2'b11, 2'b01, 2'b01);  // 17 applies at once
    step(0, 0, 0, 8'h00, 2'b00, 2'b01, 3, 1, 0, 0, 2'b11, 2'b00, 2'b00);  // 18
    step(0, 0, 0, 8'h00, 2'b00, 2'b01, 3, 1, 0, 0, 2'b11, 2'b00, 2'b00);  // 19
    step(0, 0, 0, 8'h00, 2'b00, 2'b01, 3, 1, 0, 0, 2'b10, 2'b01, 2'b01);  // 20 fourth start applies
    step(0, 1, 0, 8'h00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);  // 21 reset_nos
    step(0, 0, 0, 8'h00, 2'b00, 2'b01, 0, 1, 1, 0, 2'b01, 2'b01, 2'b01);  // 22 stride 0 acts as 1
    step(0, 0, 0, 8'h00, 2'b00, 2'b01, 0, 1, 1, 0, 2'b01, 2'b01, 2'b00);  // 23
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 3, 3, 1, 1, 2'b11, 2'b11, 2'b10);  // 24 countdowns running
    step(1, 0, 0, 8'h00, 2'b00, 2'b11, 3, 3, 1, 1, 2'b00, 2'b00, 2'b00);  // 25 rst mid-count
    step(0, 0, 0, 8'h00, 2'b00, 2'b11, 3, 3, 1, 1, 2'b00, 2'b11, 2'b00);  // 26 AND restored, phase 0
    @(negedge clk);
    start = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
